// File: rtl/mmio_pkg.sv
// Shared constants for the 4-bit core's memory-mapped I/O.
// Holds the microcycle indices (also used by the microcycle and decoder
// blocks), the default window bases and the window decode helper.
package mmio_pkg;

    // Microcycle indices within one instruction cycle.
    localparam logic [2:0] CYC_A1 = 3'd0;
    localparam logic [2:0] CYC_A2 = 3'd1;
    localparam logic [2:0] CYC_A3 = 3'd2;
    localparam logic [2:0] CYC_M1 = 3'd3;
    localparam logic [2:0] CYC_M2 = 3'd4;
    localparam logic [2:0] CYC_X1 = 3'd5;
    localparam logic [2:0] CYC_X2 = 3'd6;
    localparam logic [2:0] CYC_X3 = 3'd7;

    // Default window bases, compared against addr[11:4].
    localparam logic [7:0] ROM_IN_BASE_DEF  = 8'h7E;
    localparam logic [7:0] ROM_OUT_BASE_DEF = 8'h7F;
    localparam logic [7:0] RAM_OUT_BASE_DEF = 8'hFF;

    // A window always spans 16 port slots (addr[3:0]).
    localparam int PORT_SLOTS = 16;

    typedef enum logic [1:0] {
        WIN_NONE,
        WIN_ROM_IN,
        WIN_ROM_OUT,
        WIN_RAM_OUT
    } winSelT;

    // Classify the upper address byte. If two bases are configured equal,
    // the earlier window in this list wins.
    function automatic winSelT decodeWin(
        input logic [7:0] addrHi,
        input logic [7:0] inBase,
        input logic [7:0] outBase,
        input logic [7:0] ramBase
    );
        winSelT win;
        win = WIN_NONE;
        if (addrHi == inBase) begin
            win = WIN_ROM_IN;
        end else if (addrHi == outBase) begin
            win = WIN_ROM_OUT;
        end else if (addrHi == ramBase) begin
            win = WIN_RAM_OUT;
        end
        return win;
    endfunction

endpackage

// File: rtl/io_sync_cell.sv
// Multi-flop synchroniser for one external input nibble.
// With MMIO_IN_CHANGE_IRQ_EN defined it also flags when the synchronised
// value differs from the value it held one clock earlier.
module io_sync_cell
    import mmio_pkg::*;
#(
    parameter int NIB_W       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [NIB_W-1:0] asyncIn,
    output logic [NIB_W-1:0] syncOut
`ifdef MMIO_IN_CHANGE_IRQ_EN
    ,
    output logic             changed
`endif
);

    logic [NIB_W-1:0] chain [SYNC_STAGES];

    // Shift the raw pin value through SYNC_STAGES flops.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= asyncIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign syncOut = chain[SYNC_STAGES-1];

`ifdef MMIO_IN_CHANGE_IRQ_EN
    logic [NIB_W-1:0] prevSync;

    // Remember the last synchronised value for edge detection.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            prevSync <= '0;
        end else begin
            prevSync <= syncOut;
        end
    end

    assign changed = (syncOut != prevSync);
`endif

endmodule

// File: rtl/mmio_port_bank.sv
// Memory-mapped I/O port bank for the 4-bit core.
// Decodes the ROM-in, ROM-out and RAM-out windows from the effective address,
// registers read data on X2, commits port writes on X3 with a one-clock strobe,
// and keeps RAM writes out of the RAM-out window.
// Optional feature macro: MMIO_IN_CHANGE_IRQ_EN (input-change interrupt);
// without it irq is tied low.
//
// Request semantics: ioRe, ioWe and ramWe are level requests from the decoder
// with no back-pressure. A request acts only when it coincides with its
// microcycle (ioRe on X2, ioWe on X3) and the address hits a window; the
// bank always accepts in that clock, so there is no ready signal.
module mmio_port_bank
    import mmio_pkg::*;
#(
    parameter int         NIB_W        = 4,
    parameter int         N_IN         = 16,
    parameter int         N_OUT        = 16,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] ROM_IN_BASE  = ROM_IN_BASE_DEF,
    parameter logic [7:0] ROM_OUT_BASE = ROM_OUT_BASE_DEF,
    parameter logic [7:0] RAM_OUT_BASE = RAM_OUT_BASE_DEF
) (
    input  logic                   clk,
    input  logic                   rstN,
    input  logic [2:0]             cycle,
    input  logic [11:0]            memAddr,
    input  logic                   ioWe,
    input  logic                   ioRe,
    input  logic                   ramWe,
    input  logic [NIB_W-1:0]       dataIn,
    input  logic [N_IN*NIB_W-1:0]  ioIn,
    output logic [NIB_W-1:0]       rdData,
    output logic [N_OUT*NIB_W-1:0] romOut,
    output logic [N_OUT*NIB_W-1:0] ramOut,
    output logic [2*N_OUT-1:0]     outStb,
    output logic                   ramWeEff,
    output logic                   errFlag,
    output logic                   irq
);

    // ------------------------------------------------------------------
    // Window decode
    // ------------------------------------------------------------------
    winSelT     winSel;
    logic [3:0] port;
    logic       romInHit;
    logic       romOutHit;
    logic       ramOutHit;
    logic       inValid;
    logic       outValid;
    logic       rdEn;
    logic       wrRomEn;
    logic       wrRamEn;

    assign winSel    = decodeWin(memAddr[11:4], ROM_IN_BASE, ROM_OUT_BASE, RAM_OUT_BASE);
    assign port      = memAddr[3:0];
    assign romInHit  = (winSel == WIN_ROM_IN);
    assign romOutHit = (winSel == WIN_ROM_OUT);
    assign ramOutHit = (winSel == WIN_RAM_OUT);

    assign inValid  = ({1'b0, port} < 5'(N_IN));
    assign outValid = ({1'b0, port} < 5'(N_OUT));

    assign rdEn    = ioRe & romInHit  & (cycle == CYC_X2);
    assign wrRomEn = ioWe & romOutHit & (cycle == CYC_X3);
    assign wrRamEn = ioWe & ramOutHit & (cycle == CYC_X3);

    // The RAM array must never see a write aimed at the RAM-out window.
    assign ramWeEff = ramWe & ~ramOutHit;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [NIB_W-1:0] syncVal [N_IN];
    logic [NIB_W-1:0] syncPad [PORT_SLOTS];
`ifdef MMIO_IN_CHANGE_IRQ_EN
    logic [N_IN-1:0]  inChanged;
`endif

    for (genvar g = 0; g < N_IN; g++) begin : gSync
        io_sync_cell #(
            .NIB_W       (NIB_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) uSync (
            .clk     (clk),
            .rstN    (rstN),
            .asyncIn (ioIn[g*NIB_W +: NIB_W]),
            .syncOut (syncVal[g])
`ifdef MMIO_IN_CHANGE_IRQ_EN
            ,
            .changed (inChanged[g])
`endif
        );
    end

    // Pad synchronised inputs to a full 16-slot table so any port index is safe.
    always_comb begin
        for (int i = 0; i < PORT_SLOTS; i++) begin
            syncPad[i] = '0;
        end
        for (int i = 0; i < N_IN; i++) begin
            syncPad[i] = syncVal[i];
        end
    end

    // ------------------------------------------------------------------
    // Read data register
    // ------------------------------------------------------------------
    // Capture the addressed input on the X2 edge; unimplemented ports read 0.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= inValid ? syncPad[port] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Output port registers and strobes
    // ------------------------------------------------------------------
    logic [NIB_W-1:0]   romReg [N_OUT];
    logic [NIB_W-1:0]   ramReg [N_OUT];
    logic [2*N_OUT-1:0] stbNext;

    // One-hot strobe for the port written this clock; writes to missing ports give none.
    always_comb begin
        stbNext = '0;
        for (int i = 0; i < N_OUT; i++) begin
            stbNext[i]         = wrRomEn & outValid & (port == 4'(i));
            stbNext[N_OUT + i] = wrRamEn & outValid & (port == 4'(i));
        end
    end

    // Commit X3 writes into the out-port registers and launch the strobe.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < N_OUT; i++) begin
                romReg[i] <= '0;
                ramReg[i] <= '0;
            end
            outStb <= '0;
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                if (stbNext[i]) begin
                    romReg[i] <= dataIn;
                end
                if (stbNext[N_OUT + i]) begin
                    ramReg[i] <= dataIn;
                end
            end
            outStb <= stbNext;
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : gOutFlat
        assign romOut[g*NIB_W +: NIB_W] = romReg[g];
        assign ramOut[g*NIB_W +: NIB_W] = ramReg[g];
    end

    // ------------------------------------------------------------------
    // Sticky error flag
    // ------------------------------------------------------------------
    // Any qualified access to a port index beyond the implemented range.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            errFlag <= 1'b0;
        end else if ((rdEn & ~inValid) | ((wrRomEn | wrRamEn) & ~outValid)) begin
            errFlag <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Input-change interrupt
    // ------------------------------------------------------------------
`ifdef MMIO_IN_CHANGE_IRQ_EN
    logic [N_IN-1:0] pending;
    logic [N_IN-1:0] pendingNext;
    logic            irqQ;

    // A fresh change sets pending and beats a same-clock read clear.
    always_comb begin
        pendingNext = pending;
        for (int i = 0; i < N_IN; i++) begin
            if (inChanged[i]) begin
                pendingNext[i] = 1'b1;
            end else if (rdEn && (port == 4'(i))) begin
                pendingNext[i] = 1'b0;
            end
        end
    end

    // Register pending bits and the interrupt derived from their next state.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pending <= '0;
            irqQ    <= 1'b0;
        end else begin
            pending <= pendingNext;
            irqQ    <= |pendingNext;
        end
    end

    assign irq = irqQ;
`else
    assign irq = 1'b0;
`endif

endmodule
